// File: rtl/cordic_polar_to_rect.sv
// Iterative CORDIC polar-to-rectangular converter: ITERATIONS+3 cycles per conversion, input_ready ignored while busy.
// Defining CORDIC_DROP_COUNT_EN adds dropped_count, a saturating count of strobes ignored while busy.
module cordic_polar_to_rect #(
  parameter int INPUT_BITS = 16,
  parameter int MAG_BITS   = INPUT_BITS + 1,
  parameter int PHASE_BITS = 16,
  parameter int ITERATIONS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         input_ready,
  input  logic [MAG_BITS-1:0]          magnitude_in,
  input  logic [PHASE_BITS-1:0]        phase_in,
  output logic                         busy,
  output logic                         output_ready,
  output logic signed [INPUT_BITS-1:0] output_1,
  output logic signed [INPUT_BITS-1:0] output_2
`ifdef CORDIC_DROP_COUNT_EN
  ,
  output logic [15:0]                  dropped_count
`endif
);

  localparam int W  = MAG_BITS + 3;
  // Residual angle keeps 16 guard bits below the phase LSB so table rounding does not accumulate.
  localparam int ZW = PHASE_BITS + 18;
  localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam int PW = W + 17;
  localparam logic [CW-1:0]        LAST = CW'(ITERATIONS - 1);
  localparam logic signed [16:0]   GAIN = 17'sh04DBA;
  localparam longint               MAXL = (longint'(1) << (INPUT_BITS - 1)) - 1;
  localparam logic signed [PW-1:0] SAT_HI = PW'(MAXL);
  localparam logic signed [PW-1:0] SAT_LO = PW'(-MAXL - 1);

  typedef enum logic [1:0] {IDLE, ROTATE, SCALE, DONE} state_t;

  // atan(2^-i) as a fraction of a full turn, scaled by 2^32.
  function automatic logic [31:0] atan_tbl32(input int i);
    case (i)
      0:  return 32'h20000000;
      1:  return 32'h12E4051E;
      2:  return 32'h09FB385B;
      3:  return 32'h051111D4;
      4:  return 32'h028B0D43;
      5:  return 32'h0145D7E1;
      6:  return 32'h00A2F61E;
      7:  return 32'h00517C55;
      8:  return 32'h0028BE53;
      9:  return 32'h00145F2F;
      10: return 32'h000A2F98;
      11: return 32'h000517CC;
      12: return 32'h00028BE6;
      13: return 32'h000145F3;
      14: return 32'h0000A2FA;
      15: return 32'h0000517D;
      16: return 32'h000028BE;
      17: return 32'h0000145F;
      18: return 32'h00000A30;
      19: return 32'h00000518;
      20: return 32'h0000028C;
      21: return 32'h00000146;
      22: return 32'h000000A3;
      23: return 32'h00000051;
      24: return 32'h00000029;
      25: return 32'h00000014;
      26: return 32'h0000000A;
      27: return 32'h00000005;
      28: return 32'h00000003;
      29: return 32'h00000001;
      30: return 32'h00000001;
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic signed [ZW-1:0] atan_z(input int i);
    logic [63:0] t;
    t = {32'd0, atan_tbl32(i)};
    if (PHASE_BITS >= 16) t = t << (PHASE_BITS - 16);
    else                  t = t >> (16 - PHASE_BITS);
    return ZW'(t);
  endfunction

  // Arithmetic shift with round-to-nearest, which removes the floor bias of a plain >>>.
  function automatic logic signed [W-1:0] sra_rnd(input logic signed [W-1:0] v, input logic [CW-1:0] s);
    logic signed [W-1:0] r;
    if (s == '0) return v;
    r = v + $signed(W'(1) << (s - 1'b1));
    return r >>> s;
  endfunction

  function automatic logic signed [INPUT_BITS-1:0] scale_sat(input logic signed [W-1:0] v);
    logic signed [PW-1:0] p;
    logic [PW-1:0]        a;
    logic [PW-1:0]        r;
    logic signed [PW-1:0] q;
    p = v * GAIN;
    a = p[PW-1] ? -p : p;
    r = (a + (PW'(1) << 14)) >> 15;
    q = p[PW-1] ? -$signed(r) : $signed(r);
    if (q > SAT_HI)      q = SAT_HI;
    else if (q < SAT_LO) q = SAT_LO;
    return INPUT_BITS'(q);
  endfunction

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic signed [W-1:0]         x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]        z_q, z_d;
  logic signed [INPUT_BITS-1:0] sx_q, sx_d, sy_q, sy_d;
  logic signed [INPUT_BITS-1:0] out1_q, out1_d, out2_q, out2_d;
  logic                        rdy_q, rdy_d;
  logic signed [W-1:0]         mag_s, xs, ys;
  logic signed [ZW-1:0]        at;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    rdy_d   = 1'b0;
    mag_s   = W'(magnitude_in);
    xs      = sra_rnd(x_q, cnt_q);
    ys      = sra_rnd(y_q, cnt_q);
    at      = atan_z(int'(cnt_q));
    case (state_q)
      IDLE: begin
        if (input_ready) begin
          // Quadrant bits pick the start vector; the residual is just the low phase bits.
          case (phase_in[PHASE_BITS-1 -: 2])
            2'b00:   begin x_d = mag_s;  y_d = '0;     end
            2'b01:   begin x_d = '0;     y_d = mag_s;  end
            2'b10:   begin x_d = -mag_s; y_d = '0;     end
            default: begin x_d = '0;     y_d = -mag_s; end
          endcase
          z_d     = ZW'({phase_in[PHASE_BITS-3:0], 16'd0});
          cnt_d   = '0;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        if (!z_q[ZW-1]) begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - at;
        end else begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + at;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = SCALE;
        end
      end
      SCALE: begin
        sx_d    = scale_sat(x_q);
        sy_d    = scale_sat(y_q);
        state_d = DONE;
      end
      DONE: begin
        out1_d  = sx_q;
        out2_d  = sy_q;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      rdy_q   <= rdy_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign output_ready = rdy_q;
  assign output_1     = out1_q;
  assign output_2     = out2_q;

`ifdef CORDIC_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (input_ready && (state_q != IDLE) && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_d;
  end

  assign dropped_count = drop_q;
`endif

endmodule
